// File: rtl/traffic_pkg.sv
// Shared encodings for the pedestrian-aware two-street traffic controller.
package traffic_pkg;

    // Street lamps {red,yellow,green}
    localparam logic [2:0] S_RED    = 3'b100;
    localparam logic [2:0] S_YELLOW = 3'b010;
    localparam logic [2:0] S_GREEN  = 3'b001;
    localparam logic [2:0] S_OFF    = 3'b000;

    // Walk lamps {red,green}
    localparam logic [1:0] W_RED    = 2'b10;
    localparam logic [1:0] W_GREEN  = 2'b01;
    localparam logic [1:0] W_OFF    = 2'b00;

    // State codes, exported unchanged on the phase debug output
    typedef enum logic [3:0] {
        ST_A_GREEN    = 4'd0,
        ST_A_YELLOW   = 4'd1,
        ST_ALL_RED    = 4'd2,
        ST_B_GREEN    = 4'd3,
        ST_B_YELLOW   = 4'd4,
        ST_WALK       = 4'd5,
        ST_WALK_FLASH = 4'd6,
        ST_NIGHT      = 4'd7
    } state_t;

    // Where ALL_RED goes when it expires and night mode is not requested
    typedef enum logic [1:0] {
        TGT_B_GREEN = 2'd0,
        TGT_SERVICE = 2'd1,
        TGT_A_GREEN = 2'd2
    } target_t;

endpackage

// File: rtl/traffic_controller_ped_tick_prescaler.sv
// Divides the system clock into a single-cycle tick enable.
// With TICK_DIV=1 the counter never leaves 0, so tick is constantly 1.
module tick_prescaler #(
    parameter int TICK_DIV = 100000000,
    parameter int PRESC_W  = 27
) (
    input  logic CLK,
    input  logic RST,
    output logic tick
);

    logic [PRESC_W-1:0] count;

    assign tick = (count == PRESC_W'(TICK_DIV - 1));

    // Count 0..TICK_DIV-1 and wrap on the tick cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/traffic_controller_ped.sv
// Two-street traffic controller with latched pedestrian phase, all-red
// clearance between directions and a night flashing mode.
// Lamps are decoded from registered state only; inputs never reach outputs
// combinationally.
module traffic_controller_ped
    import traffic_pkg::*;
#(
    parameter int TICK_DIV     = 100000000,
    parameter int PRESC_W      = 27,
    parameter int TIMER_W      = 8,
    parameter int T_GREEN_A    = 12,
    parameter int T_YELLOW_A   = 4,
    parameter int T_GREEN_B    = 12,
    parameter int T_YELLOW_B   = 4,
    parameter int T_CLEAR      = 1,
    parameter int T_WALK       = 8,
    parameter int FLASH_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ped_req,
    input  logic       night,
    output logic [2:0] lighta,
    output logic [2:0] lightb,
    output logic [1:0] lightw,
    output logic       ped_wait,
    output logic [3:0] phase
);

    state_t             state, state_nx;
    target_t            target, target_nx;
    logic [TIMER_W-1:0] timer, timer_nx;
    logic               toggle, toggle_nx;
    logic               ped_pending, ped_pending_nx;
    logic               tick;
    logic               expire;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .PRESC_W  (PRESC_W)
    ) u_presc (
        .CLK  (CLK),
        .RST  (RST),
        .tick (tick)
    );

    // A timed phase ends on the tick that consumes its last unit
    assign expire = tick && (timer == TIMER_W'(1));

    // State register; reset aborts any phase back to A_GREEN
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_A_GREEN;
            timer       <= TIMER_W'(T_GREEN_A);
            target      <= TGT_B_GREEN;
            toggle      <= 1'b0;
            ped_pending <= 1'b0;
        end else begin
            state       <= state_nx;
            timer       <= timer_nx;
            target      <= target_nx;
            toggle      <= toggle_nx;
            ped_pending <= ped_pending_nx;
        end
    end

    // Next-state, timer reload, flash toggle and pedestrian latch
    always_comb begin
        state_nx  = state;
        target_nx = target;
        toggle_nx = toggle;
        timer_nx  = tick ? (timer - TIMER_W'(1)) : timer;
        case (state)
            ST_A_GREEN: if (expire) begin
                state_nx = ST_A_YELLOW;
                timer_nx = TIMER_W'(T_YELLOW_A);
            end
            ST_A_YELLOW: if (expire) begin
                state_nx  = ST_ALL_RED;
                timer_nx  = TIMER_W'(T_CLEAR);
                target_nx = TGT_B_GREEN;
            end
            ST_B_GREEN: if (expire) begin
                state_nx = ST_B_YELLOW;
                timer_nx = TIMER_W'(T_YELLOW_B);
            end
            ST_B_YELLOW: if (expire) begin
                state_nx  = ST_ALL_RED;
                timer_nx  = TIMER_W'(T_CLEAR);
                target_nx = TGT_SERVICE;
            end
            ST_ALL_RED: if (expire) begin
                if (night) begin
                    state_nx  = ST_NIGHT;
                    toggle_nx = 1'b0;
                end else if (target == TGT_B_GREEN) begin
                    state_nx = ST_B_GREEN;
                    timer_nx = TIMER_W'(T_GREEN_B);
                end else if ((target == TGT_SERVICE) && ped_pending) begin
                    state_nx = ST_WALK;
                    timer_nx = TIMER_W'(T_WALK);
                end else begin
                    state_nx = ST_A_GREEN;
                    timer_nx = TIMER_W'(T_GREEN_A);
                end
            end
            ST_WALK: if (expire) begin
                state_nx  = ST_WALK_FLASH;
                timer_nx  = TIMER_W'(FLASH_CYCLES);
                toggle_nx = 1'b0;
            end
            ST_WALK_FLASH: begin
                if (tick) toggle_nx = ~toggle;
                if (expire) begin
                    state_nx = ST_A_GREEN;
                    timer_nx = TIMER_W'(T_GREEN_A);
                end
            end
            ST_NIGHT: begin
                timer_nx = timer;
                if (tick) begin
                    if (!night) begin
                        state_nx  = ST_ALL_RED;
                        timer_nx  = TIMER_W'(T_CLEAR);
                        target_nx = TGT_A_GREEN;
                    end else begin
                        toggle_nx = ~toggle;
                    end
                end
            end
            default: begin
                state_nx = ST_A_GREEN;
                timer_nx = TIMER_W'(T_GREEN_A);
            end
        endcase

        // Entering WALK serves the request; clearing beats a new press
        ped_pending_nx = ped_pending;
        if ((state_nx == ST_WALK) && (state != ST_WALK)) begin
            ped_pending_nx = 1'b0;
        end else if (ped_req && (state != ST_WALK)) begin
            ped_pending_nx = 1'b1;
        end
    end

    // Lamp decode from registered state and flash toggle
    always_comb begin
        lighta = S_RED;
        lightb = S_RED;
        lightw = W_RED;
        case (state)
            ST_A_GREEN:    lighta = S_GREEN;
            ST_A_YELLOW:   lighta = S_YELLOW;
            ST_B_GREEN:    lightb = S_GREEN;
            ST_B_YELLOW:   lightb = S_YELLOW;
            ST_WALK:       lightw = W_GREEN;
            ST_WALK_FLASH: lightw = toggle ? W_RED : W_OFF;
            ST_NIGHT: begin
                lightw = W_OFF;
                lighta = toggle ? S_OFF : S_YELLOW;
                lightb = toggle ? S_OFF : S_RED;
            end
            default: ;
        endcase
    end

    assign ped_wait = ped_pending;
    assign phase    = state;

endmodule
